// File: rtl/aligner_pkg.sv
// Payload type and pipeline-split helpers for the pipelined alignment shifter.
// The payload struct is sized from ALN_WIDTH/ALN_CNT_W; the top's WIDTH and CNT_W must match them.
package aligner_pkg;

  localparam int ALN_WIDTH = 24;
  localparam int ALN_CNT_W = 6;

  function automatic int result_width(input int width);
    return 2 * width;
  endfunction

  localparam int ALN_RES_W = result_width(ALN_WIDTH);

  typedef struct packed {
    logic [ALN_RES_W-1:0] data;
    logic                 sticky;
    logic [ALN_CNT_W-1:0] cnt;
    logic                 dir;
  } stage_t;

  // Levels are split evenly; the first (cnt_w % stages) stages take one extra level.
  function automatic int stage_levels(input int cnt_w, input int stages, input int s);
    return (cnt_w / stages) + ((s < (cnt_w % stages)) ? 1 : 0);
  endfunction

  function automatic int stage_first_level(input int cnt_w, input int stages, input int s);
    return (s * (cnt_w / stages)) + ((s < (cnt_w % stages)) ? s : (cnt_w % stages));
  endfunction

  function automatic int level_stage(input int cnt_w, input int stages, input int k);
    int s;
    s = 0;
    for (int i = 1; i < stages; i++) begin
      if (k >= stage_first_level(cnt_w, stages, i)) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/aligner_shift_level.sv
// One conditional power-of-two shift level; discarded bits are ORed into the running sticky.
// Purely combinational; a SHIFT at or beyond WIDTH discards the whole field.
module aligner_shift_level #(
  parameter int WIDTH = 48,
  parameter int SHIFT = 1
) (
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sticky_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky_out
);

  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] ldata;
  logic             rlost;
  logic             llost;

  if (SHIFT >= WIDTH) begin : g_all
    assign rdata = '0;
    assign ldata = '0;
    assign rlost = |data_in;
    assign llost = |data_in;
  end else begin : g_part
    assign rdata = {{SHIFT{1'b0}}, data_in[WIDTH-1:SHIFT]};
    assign ldata = {data_in[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
    assign rlost = |data_in[SHIFT-1:0];
    assign llost = |data_in[WIDTH-1:WIDTH-SHIFT];
  end

  always_comb begin
    data_out   = data_in;
    sticky_out = sticky_in;
    if (en) begin
      data_out   = dir ? ldata : rdata;
      sticky_out = sticky_in | (dir ? llost : rlost);
    end
  end

endmodule

// File: rtl/aligner_shift_pipe.sv
// Pipelined aligner: result = {operand,0} >> shift_count with sticky; latency STAGES, 1/cycle, stalls on out_ready.
// in_ready is combinational from out_ready (no skid). ALIGNER_SHIFT_DIR_EN adds the shift_left port.
module aligner_shift_pipe
  import aligner_pkg::*;
#(
  parameter int WIDTH  = ALN_WIDTH,
  parameter int CNT_W  = ALN_CNT_W,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CNT_W-1:0]   shift_count,
  input  logic [WIDTH-1:0]   operand,
`ifdef ALIGNER_SHIFT_DIR_EN
  input  logic               shift_left,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               sticky
);

  localparam int RES_W = result_width(WIDTH);
  localparam int LAST  = STAGES - 1;

  stage_t            src;
  stage_t            lvl_in  [CNT_W];
  stage_t            lvl_out [CNT_W];
  stage_t            stg_nxt [STAGES];
  stage_t            stg_q   [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              unused_tail;

  always_comb begin
    src        = '0;
    src.cnt    = shift_count;
    src.sticky = 1'b0;
`ifdef ALIGNER_SHIFT_DIR_EN
    src.dir  = shift_left;
    src.data = shift_left ? {{WIDTH{1'b0}}, operand} : {operand, {WIDTH{1'b0}}};
`else
    src.dir  = 1'b0;
    src.data = {operand, {WIDTH{1'b0}}};
`endif
  end

  // Saturation needs no special case: once the applied levels sum past RES_W every
  // operand bit has been discarded into the sticky.
  for (genvar k = 0; k < CNT_W; k++) begin : g_lvl
    localparam int S = level_stage(CNT_W, STAGES, k);
    logic [RES_W-1:0] d;
    logic             st;

    if (k == stage_first_level(CNT_W, STAGES, S)) begin : g_head
      if (S == 0) begin : g_src
        assign lvl_in[k] = src;
      end else begin : g_reg
        assign lvl_in[k] = stg_q[S-1];
      end
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    aligner_shift_level #(
      .WIDTH (RES_W),
      .SHIFT (1 << k)
    ) u_level (
      .en         (lvl_in[k].cnt[k]),
      .dir        (lvl_in[k].dir),
      .data_in    (lvl_in[k].data),
      .sticky_in  (lvl_in[k].sticky),
      .data_out   (d),
      .sticky_out (st)
    );

    assign lvl_out[k] = '{data: d, sticky: st, cnt: lvl_in[k].cnt, dir: lvl_in[k].dir};
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_nxt
    assign stg_nxt[s] = lvl_out[stage_first_level(CNT_W, STAGES, s) + stage_levels(CNT_W, STAGES, s) - 1];
  end

  always_comb begin
    adv       = '0;
    adv[LAST] = vld_q[LAST] & out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv[s] = vld_q[s] & (~vld_q[s+1] | adv[s+1]);
    end
  end

  assign in_ready = ~vld_q[0] | adv[0];

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int s = 1; s < STAGES; s++) begin
      load[s] = adv[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= load | (vld_q & ~adv);
    end
  end

  // Payload only moves on a load, so a stalled or bubbled stage keeps its contents.
  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (load[s]) stg_q[s] <= stg_nxt[s];
    end
  end

  assign out_valid   = vld_q[LAST];
  assign result      = vld_q[LAST] ? stg_q[LAST].data : '0;
  assign sticky      = vld_q[LAST] & stg_q[LAST].sticky;
  assign unused_tail = ^{stg_q[LAST].cnt, stg_q[LAST].dir};

endmodule

// File: doc/aligner_shift_pipe.md
Name: aligner_shift_pipe

Overview:
- Parametrised, pipelined alignment right-shifter for the FPU add/sub path; next generation of the fixed 24-bit combinational aligner.
- Takes a WIDTH-bit significand and places it in the upper half of a 2*WIDTH field, then shifts right by a count.
- Adds a sticky output, saturating large shifts, a configurable number of pipeline register stages and valid/ready flow control.
- Sits between exponent-difference logic and the significand adder.

Parameters:
- WIDTH, 24, operand significand width. Result is 2*WIDTH bits.
- CNT_W, 6, shift_count width. Counts range 0..2^CNT_W-1 and may exceed 2*WIDTH.
- STAGES, 2, number of register stages. Range 1..CNT_W. Shift levels are split as evenly as possible, with earlier stages taking the extra level.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept the input this cycle
- shift_count  in  CNT_W  right-shift amount
- operand  in  WIDTH  significand to align
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- result  out  2*WIDTH  aligned value
- sticky  out  1  OR of every operand bit shifted below result[0]

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `reset`.
- Function: result = ({operand, WIDTH'b0} >> shift_count) truncated to 2*WIDTH bits.
- sticky = 1 iff any operand bit lands below bit 0 after the shift.
- Shift level k (2^k) is one conditional shift. Each level ORs its discarded low bits into a running sticky carried alongside the data.
- Saturation: if shift_count >= 2*WIDTH, result = 0 and sticky = |operand.
- Latency: a transaction accepted at edge N presents out_valid at edge N+STAGES, provided there is no back-pressure. Throughput is 1 per cycle.
- Each stage holds a valid flag, the partial data, the partial sticky and the remaining count bits.
- Stage i advances when its successor is empty or is advancing. The final stage advances when out_ready=1.
- in_ready = !valid[0] | advance[0]. It is combinational from out_ready; no skid buffer.
- Transfer occurs on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- out_valid, result and sticky stay stable while out_valid=1 and out_ready=0.
- Full pipeline with out_ready=0 gives in_ready=0. Simultaneous accept and emit when full keeps throughput 1 per cycle.
- No transaction is lost, duplicated or reordered.
- Reset: all stage valid flags are 0; out_valid=0, result=0, sticky=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation flushes every in-flight transaction. Data registers may clear or hold, but outputs are masked to 0 while out_valid=0.
- A data-register update with a valid bubble (stage empty, not loading) must not change result while out_valid=1.

Optional Feature:
- Macro ALIGNER_SHIFT_DIR_EN.
- When defined: adds input port shift_left (1 bit), captured with the transaction.
  - shift_left=1 computes result = ({WIDTH'b0, operand} << shift_count) truncated to 2*WIDTH bits.
  - sticky = OR of bits shifted above result's MSB, i.e. overflow.
  - Saturation rules apply symmetrically.
- When undefined: the port is absent and behaviour is right-shift only.

Decomposition:
- Package aligner_pkg holds:
  - The typedef for the stage payload struct (data, sticky, remaining count, dir).
  - A function computing levels-per-stage from CNT_W and STAGES.
  - The localparam for result width.
- Natural sub-module: aligner_shift_level. It takes a parameter SHIFT (power of two) and WIDTH, plus enable, data in and sticky in, and produces data out and sticky out. It is purely combinational and is instantiated CNT_W times.

Test Plan (WIDTH=24, CNT_W=6, STAGES=2):
- Count 0, 24, 47: operand=0x800001 with count=0 -> result=0x800001000000, sticky=0. count=24 -> result=0x000000800001, sticky=0. count=47 -> result=0x000000000001, sticky=1. Each out_valid arrives 2 cycles after accept.
- Saturation: operand=0x000001, count=48 and count=63 -> result=0, sticky=1. operand=0, count=60 -> result=0, sticky=0.
- Back-pressure: 5 back-to-back inputs with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepts and outputs are held stable. When out_ready=1, all 5 emerge in order with no gaps or duplicates.
- Streaming: in_valid=out_ready=1 for 100 random vectors -> one result per cycle, matching the reference model bit-exactly (result and sticky).
- Reset mid-flight: reset asserted 1 cycle with 2 transactions in flight -> next cycle out_valid=0, result=0, sticky=0, in_ready=1, and no stale result is emitted afterwards.
- ALIGNER_SHIFT_DIR_EN: shift_left=1, operand=0xC00000, count=1 -> result=0x000001800000, sticky=0. count=48 -> result=0, sticky=1.
